ysyx_22041412_div_unit: RTL and testbench
=========================================

Name: ysyx_22041412_div_unit

Overview:
Parametrised iterative radix-2 integer divider for the EX stage. It handles all RV64M divide/remainder ops: DIV, DIVU, REM, REMU and the W variants. It replaces the fixed 64-bit divider with the following:
- XLEN-generic datapath.
- Two-sided valid/ready handshake.
- Early completion for special cases.
- Flush for pipeline kill.
It sits beside the combinational ALU, which muxes its result onto the EX result bus when div_en is set.

Parameters:
XLEN, 64, operand/result width; must be even and >= 8
FAST_SPECIAL, 1, 1: divide-by-zero and signed overflow complete without iterating; 0: they iterate like normal ops

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  abort any in-flight op, drop any pending result
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
dividend  in  XLEN  operand A
divisor  in  XLEN  operand B
div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
div_mode  in  1  0 = quotient, 1 = remainder
divw  in  1  1 = W op: use low XLEN/2 bits, sign-extend result
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
div_result  out  XLEN  selected quotient or remainder

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, div_result=0, all internal registers 0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch operands and controls.
    - If a special case applies and FAST_SPECIAL=1 -> DONE.
    - Otherwise -> CALC with cnt=N, where N = XLEN, or XLEN/2 when divw.
  - CALC: in_ready=0. Each cycle perform one restoring shift-subtract step on magnitudes and decrement cnt. When cnt reaches 1, the next state is DONE.
  - DONE: out_valid=1 and div_result is stable. On out_ready -> IDLE. Results are never overwritten while waiting (hold under back-pressure).
- No accept in DONE. The earliest next accept is the cycle after the out_valid&out_ready handshake.
- Latency, accept edge to out_valid high:
  - Normal op: N+1 cycles (65 for 64-bit, 33 for W at XLEN=64).
  - Special case with FAST_SPECIAL=1: 1 cycle.
- Signed handling:
  - Magnitudes are taken at accept.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Both fixups are applied when entering DONE.
- W mode:
  - Operands are truncated to XLEN/2 bits; the sign bit is bit XLEN/2-1.
  - The final XLEN/2-bit result is sign-extended to XLEN, including for DIVUW/REMUW.
- Special cases, in effective width w:
  - Divisor 0: quotient = all ones; remainder = dividend (width w, then sign-extended if W).
  - Signed overflow (A = most-negative, B = -1): quotient = A; remainder = 0.
  - Both give the same results with FAST_SPECIAL=0; only latency differs.
- Flush:
  - Takes priority over everything except rst.
  - In any state, next cycle state=IDLE, out_valid=0, in_ready=1.
  - A request presented in the same cycle as flush is not accepted.
- Reset mid-CALC or mid-DONE: same as flush; div_result is cleared to 0.
- out_ready while out_valid=0: ignored.
- Operand changes after accept: no effect.

Decomposition:
- Package ysyx_22041412_div_pkg holds:
  - State enum {IDLE, CALC, DONE}.
  - Localparam helpers: half width, counter width $clog2(XLEN+1).
  - Special-case code {NONE, DIVZERO, OVERFLOW}.
- One sub-module, ysyx_22041412_div_prep (combinational). It does:
  - W truncation/sign extension of inputs.
  - abs() of operands.
  - Sign flags and special-case detection.
- The top level holds the FSM, counter, partial-remainder/quotient shift registers and the output fixup/sign-extend.

Test Plan:
- XLEN=64: DIVU 100/7 -> out_valid 65 cycles after accept; quotient 14 (div_mode=0); repeated with REMU gives 2.
- DIV -7/2 signed -> quotient 0xFFFFFFFFFFFFFFFD; REM -> 0xFFFFFFFFFFFFFFFF.
- Divide by zero, FAST_SPECIAL=1: DIVU 0x1234/0 -> quotient 0xFFFFFFFFFFFFFFFF and REMU gives 0x1234, each 1 cycle after accept.
- Overflow: DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM -> 0. DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
- W mode: DIVUW 0xDEAD_FFFFFFFF / 1 -> 0xFFFFFFFFFFFFFFFF after 33 cycles. REMW -7/3 (low words) -> 0xFFFFFFFFFFFFFFFF.
- Back-pressure and flush:
  - Hold out_ready=0 for 5 cycles: div_result stable, in_ready=0.
  - Assert flush at CALC cycle 10: next cycle out_valid=0 and in_ready=1. A new DIVU 9/3 then returns 3 with no residue from the killed op.

Source files
------------

// File: rtl/ysyx_22041412_div_pkg.sv
// Shared types and width helpers for the iterative radix-2 divider.
package ysyx_22041412_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    typedef enum logic [1:0] {
        SPC_NONE     = 2'd0,
        SPC_DIVZERO  = 2'd1,
        SPC_OVERFLOW = 2'd2
    } div_special_e;

    function automatic int half_w(input int xlen);
        return xlen / 2;
    endfunction

    function automatic int cnt_w(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/ysyx_22041412_div_if.sv
// Request/response handshake bundle between the EX stage and the divider.
interface ysyx_22041412_div_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_signed;
    logic            div_mode;
    logic            divw;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_result;

    modport master (
        output in_valid, dividend, divisor, div_signed, div_mode, divw, out_ready,
        input  in_ready, out_valid, div_result
    );

    modport slave (
        input  in_valid, dividend, divisor, div_signed, div_mode, divw, out_ready,
        output in_ready, out_valid, div_result
    );
endinterface

// File: rtl/ysyx_22041412_div_prep.sv
// Operand conditioning: W truncation, magnitudes, result signs and special-case detection.
module ysyx_22041412_div_prep
    import ysyx_22041412_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            divw,
    output logic [XLEN-1:0] a_ext,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            neg_q,
    output logic            neg_r,
    output div_special_e    special
);
    localparam int HALF = half_w(XLEN);

    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_neg;
    logic            sign_a;
    logic            sign_b;

    function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] v, input logic sgn);
        return {{HALF{sgn & v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        a_ext   = divw ? narrow(dividend, div_signed) : dividend;
        b_ext   = divw ? narrow(divisor, div_signed) : divisor;
        // Most-negative value of the effective width, as it appears after sign extension
        min_neg = divw ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}} : {1'b1, {(XLEN - 1){1'b0}}};
        sign_a  = div_signed & a_ext[XLEN-1];
        sign_b  = div_signed & b_ext[XLEN-1];
        a_mag   = abs_val(a_ext, sign_a);
        b_mag   = abs_val(b_ext, sign_b);
        neg_q   = sign_a ^ sign_b;
        neg_r   = sign_a;
        special = SPC_NONE;
        if (b_ext == '0) begin
            special = SPC_DIVZERO;
        end else if (div_signed && a_ext == min_neg && b_ext == '1) begin
            special = SPC_OVERFLOW;
        end
    end

endmodule

// File: rtl/ysyx_22041412_div_unit.sv
// Iterative restoring radix-2 divider for RV64M DIV/REM families with valid/ready handshakes.
module ysyx_22041412_div_unit
    import ysyx_22041412_div_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    ysyx_22041412_div_if.slave    bus
);
    localparam int HALF  = half_w(XLEN);
    localparam int CNT_W = cnt_w(XLEN);

    div_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] bmag_q;
    logic [XLEN-1:0] aext_q;
    logic            negq_q;
    logic            negr_q;
    logic            mode_q;
    logic            w_q;
    div_special_e    spc_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_q;
    logic            neg_r;
    div_special_e    special;

    ysyx_22041412_div_prep #(.XLEN(XLEN)) u_prep (
        .dividend   (bus.dividend),
        .divisor    (bus.divisor),
        .div_signed (bus.div_signed),
        .divw       (bus.divw),
        .a_ext      (a_ext),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .neg_q      (neg_q),
        .neg_r      (neg_r),
        .special    (special)
    );

    function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] v);
        return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    // Special cases override the iterated magnitudes so both FAST_SPECIAL settings agree
    function automatic logic [XLEN-1:0] fixup(
        input div_special_e    spc,
        input logic            mode,
        input logic            w,
        input logic            nq,
        input logic            nr,
        input logic [XLEN-1:0] aext,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r
    );
        logic [XLEN-1:0] v;
        case (spc)
            SPC_DIVZERO:  v = mode ? aext : '1;
            SPC_OVERFLOW: v = mode ? '0 : aext;
            default:      v = mode ? (nr ? -r : r) : (nq ? -q : q);
        endcase
        return w ? sext_half(v) : v;
    endfunction

    logic [XLEN:0]   r_shift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;

    always_comb begin
        r_shift = {rem_q, quo_q[XLEN-1]};
        diff    = r_shift - {1'b0, bmag_q};
        rem_nx  = diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            bmag_q      <= '0;
            aext_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            mode_q      <= 1'b0;
            w_q         <= 1'b0;
            spc_q       <= SPC_NONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        rem_q      <= '0;
                        quo_q      <= bus.divw ? (a_mag << HALF) : a_mag;
                        bmag_q     <= b_mag;
                        aext_q     <= a_ext;
                        negq_q     <= neg_q;
                        negr_q     <= neg_r;
                        mode_q     <= bus.div_mode;
                        w_q        <= bus.divw;
                        spc_q      <= special;
                        in_ready_q <= 1'b0;
                        if (FAST_SPECIAL && special != SPC_NONE) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= fixup(special, bus.div_mode, bus.divw, neg_q, neg_r,
                                                 a_ext, '0, '0);
                        end else begin
                            state_q <= ST_CALC;
                            cnt_q   <= bus.divw ? CNT_W'(HALF) : CNT_W'(XLEN);
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fixup(spc_q, mode_q, w_q, negq_q, negr_q,
                                             aext_q, quo_nx, rem_nx);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.div_result = result_q;

endmodule

// File: tb/tb_ysyx_22041412_div_unit.sv
// Self-checking bench for the iterative divider: directed, randomized, back-pressure, flush, reset.
module tb_ysyx_22041412_div_unit;

    logic clk;
    logic rst;
    logic flush;
    int   total_cnt;
    int   pass_cnt;

    ysyx_22041412_div_if #(.XLEN(64)) bus ();

    ysyx_22041412_div_unit #(.XLEN(64), .FAST_SPECIAL(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
        logic        mode;
        logic        w;
        logic [63:0] exp;
        logic [7:0]  lat;
    } vec_t;

    // RISC-V M-extension semantics computed with native operators
    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic sgn, input logic mode, input logic w);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic [63:0] r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) r32 = mode ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = mode ? 32'd0 : a32;
            else if (sgn) r32 = mode ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else r32 = mode ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) r64 = mode ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = mode ? 64'd0 : a;
        else if (sgn) r64 = mode ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else r64 = mode ? a % b : a / b;
        return r64;
    endfunction

    function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b,
                                       input logic sgn, input logic w);
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        return 65;
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                          input logic mode, input logic w,
                          output logic [63:0] res, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_signed = sgn;
        bus.div_mode   = mode;
        bus.divw       = w;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.dividend   = ~a;
        bus.divisor    = ~b;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.div_result;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.div_result !== 64'd0) $display("FAIL reset_result: got %h expected 0", bus.div_result);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        dv [11];
        logic [63:0] res;
        int          lat;
        dv[0]  = '{a:64'd100, b:64'd7, sgn:1'b0, mode:1'b0, w:1'b0, exp:64'd14, lat:8'd65};
        dv[1]  = '{a:64'd100, b:64'd7, sgn:1'b0, mode:1'b1, w:1'b0, exp:64'd2, lat:8'd65};
        dv[2]  = '{a:-64'sd7, b:64'd2, sgn:1'b1, mode:1'b0, w:1'b0, exp:64'hFFFF_FFFF_FFFF_FFFD, lat:8'd65};
        dv[3]  = '{a:-64'sd7, b:64'd2, sgn:1'b1, mode:1'b1, w:1'b0, exp:64'hFFFF_FFFF_FFFF_FFFF, lat:8'd65};
        dv[4]  = '{a:64'h1234, b:64'd0, sgn:1'b0, mode:1'b0, w:1'b0, exp:64'hFFFF_FFFF_FFFF_FFFF, lat:8'd1};
        dv[5]  = '{a:64'h1234, b:64'd0, sgn:1'b0, mode:1'b1, w:1'b0, exp:64'h1234, lat:8'd1};
        dv[6]  = '{a:64'h8000_0000_0000_0000, b:64'hFFFF_FFFF_FFFF_FFFF, sgn:1'b1, mode:1'b0, w:1'b0,
                   exp:64'h8000_0000_0000_0000, lat:8'd1};
        dv[7]  = '{a:64'h8000_0000_0000_0000, b:64'hFFFF_FFFF_FFFF_FFFF, sgn:1'b1, mode:1'b1, w:1'b0,
                   exp:64'd0, lat:8'd1};
        dv[8]  = '{a:64'h8000_0000, b:64'hFFFF_FFFF, sgn:1'b1, mode:1'b0, w:1'b1,
                   exp:64'hFFFF_FFFF_8000_0000, lat:8'd1};
        dv[9]  = '{a:64'hDEAD_FFFF_FFFF, b:64'd1, sgn:1'b0, mode:1'b0, w:1'b1,
                   exp:64'hFFFF_FFFF_FFFF_FFFF, lat:8'd33};
        dv[10] = '{a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd3, sgn:1'b1, mode:1'b1, w:1'b1,
                   exp:64'hFFFF_FFFF_FFFF_FFFF, lat:8'd33};
        for (int i = 0; i < 11; i++) begin
            run_op(dv[i].a, dv[i].b, dv[i].sgn, dv[i].mode, dv[i].w, res, lat);
            total_cnt++;
            if (res !== dv[i].exp) $display("FAIL directed_%0d_result: got %h expected %h", i, res, dv[i].exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != int'(dv[i].lat)) $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, dv[i].lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
        logic        mode;
        logic        w;
        logic [63:0] res;
        logic [63:0] exp;
        int          lat;
        int          pick;
        for (int i = 0; i < 40; i++) begin
            a    = {$urandom, $urandom} >> $urandom_range(0, 63);
            b    = {$urandom, $urandom} >> $urandom_range(0, 63);
            sgn  = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) a = -a;
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                b = w ? {$urandom, 32'd0} : 64'd0;
            end else if (pick == 1) begin
                sgn = 1'b1;
                a   = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b   = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
            end
            exp = ref_result(a, b, sgn, mode, w);
            run_op(a, b, sgn, mode, w, res, lat);
            total_cnt++;
            if (res !== exp)
                $display("FAIL random_%0d_result: a=%h b=%h s=%b m=%b w=%b got %h expected %h",
                         i, a, b, sgn, mode, w, res, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != ref_latency(a, b, sgn, w))
                $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, ref_latency(a, b, sgn, w));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int guard;
        bus.dividend   = 64'd1000;
        bus.divisor    = 64'd10;
        bus.div_signed = 1'b0;
        bus.div_mode   = 1'b0;
        bus.divw       = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.dividend = 64'd7;
        bus.divisor  = 64'd7;
        guard = 0;
        while (bus.out_valid !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (bus.div_result !== 64'd100) $display("FAIL hold_%0d_result: got %h expected %h", i, bus.div_result, 64'd100);
            else pass_cnt++;
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL hold_%0d_in_ready: got %b expected 0", i, bus.in_ready);
            else pass_cnt++;
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL hold_%0d_out_valid: got %b expected 1", i, bus.out_valid);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL release_out_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat;
        int          spurious;
        bus.dividend   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.divisor    = 64'd3;
        bus.div_signed = 1'b0;
        bus.div_mode   = 1'b0;
        bus.divw       = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush        = 1'b1;
        bus.dividend = 64'd50;
        bus.divisor  = 64'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
        else pass_cnt++;
        spurious = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) spurious++;
        end
        total_cnt++;
        if (spurious != 0) $display("FAIL flush_no_residue: got %0d valid cycles expected 0", spurious);
        else pass_cnt++;
        run_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat);
        total_cnt++;
        if (res !== 64'd3) $display("FAIL flush_next_result: got %h expected %h", res, 64'd3);
        else pass_cnt++;
        total_cnt++;
        if (lat != 65) $display("FAIL flush_next_latency: got %0d expected 65", lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat;
        run_op(64'd81, 64'd9, 1'b0, 1'b0, 1'b1, res, lat);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_after_handshake: got %b expected 1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (res !== 64'd9) $display("FAIL b2b_first_result: got %h expected %h", res, 64'd9);
        else pass_cnt++;
        run_op(-64'sd100, 64'd7, 1'b1, 1'b1, 1'b0, res, lat);
        total_cnt++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL b2b_second_result: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFE);
        else pass_cnt++;
        total_cnt++;
        if (lat != 65) $display("FAIL b2b_second_latency: got %0d expected 65", lat);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        bus.dividend   = 64'd12345;
        bus.divisor    = 64'd17;
        bus.div_signed = 1'b0;
        bus.div_mode   = 1'b0;
        bus.divw       = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b expected 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.div_result !== 64'd0) $display("FAIL midreset_result: got %h expected 0", bus.div_result);
        else pass_cnt++;
    endtask

    initial begin
        total_cnt      = 0;
        pass_cnt       = 0;
        rst            = 1'b1;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.dividend   = 64'd0;
        bus.divisor    = 64'd0;
        bus.div_signed = 1'b0;
        bus.div_mode   = 1'b0;
        bus.divw       = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
